// File: rtl/if_stage_pkg.sv
// if_stage_pkg: values shared by the instruction-fetch stage and its IF/ID register.
//   - default reset PC and the bubble instruction word (sll $0,$0,0)
//   - 2-bit fetch FSM encoding: BOOT=0, RUN=1, HALTED=2
//   - IF/ID field widths
package if_stage_pkg;

    localparam int unsigned IF_PC_W    = 32;
    localparam int unsigned IF_INSTR_W = 32;

    localparam logic [IF_PC_W-1:0]    IF_RESET_PC  = 32'h0000_0000;
    localparam logic [IF_INSTR_W-1:0] IF_NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] ST_BOOT   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   clk, rst          clock and asynchronous active-low reset (reset = bubble)
//   load_en           update the register this edge; otherwise it holds
//   bubble            when loading, write a bubble instead of the fetched word
//   pc_in/pc_plus4_in/instr_in   fetched instruction and its addresses
//   id_pc/id_pc_plus4/id_instr/id_valid   register contents
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [IF_INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_en,
    input  logic                  bubble,
    input  logic [IF_PC_W-1:0]    pc_in,
    input  logic [IF_PC_W-1:0]    pc_plus4_in,
    input  logic [IF_INSTR_W-1:0] instr_in,
    output logic [IF_PC_W-1:0]    id_pc,
    output logic [IF_PC_W-1:0]    id_pc_plus4,
    output logic [IF_INSTR_W-1:0] id_instr,
    output logic                  id_valid
);

    logic [IF_PC_W-1:0]    pc_q, pc_d;
    logic [IF_PC_W-1:0]    pc_plus4_q, pc_plus4_d;
    logic [IF_INSTR_W-1:0] instr_q, instr_d;
    logic                  valid_q, valid_d;

    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (load_en) begin
            if (bubble) begin
                pc_d       = '0;
                pc_plus4_d = '0;
                instr_d    = NOP_INSTR;
                valid_d    = 1'b0;
            end else begin
                pc_d       = pc_in;
                pc_plus4_d = pc_plus4_in;
                instr_d    = instr_in;
                valid_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign id_pc       = pc_q;
    assign id_pc_plus4 = pc_plus4_q;
    assign id_instr    = instr_q;
    assign id_valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, drives the combinational
// instruction memory and loads the returned word into IF/ID.
//   clk, rst            clock and asynchronous active-low reset
//   stall, flush        hazard freeze / squash of the IF/ID load
//   redirect_valid/pc   taken branch or jump target from EX
//   halt_req, resume    debug halt handshake
//   iaddr, idata        instruction memory address (== PC) and returned word
//   id_*                IF/ID register contents
//   misalign            one-cycle pulse when a redirect target was not word aligned
//   halted              fetch FSM is HALTED
//   dbg_state           raw fetch FSM state (BOOT=0, RUN=1, HALTED=2)
// No handshake is used: idata must be valid in the same cycle iaddr is driven,
// and every input is sampled on the rising edge of clk.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [IF_PC_W-1:0]    RESET_PC  = IF_RESET_PC,
    parameter logic [IF_INSTR_W-1:0] NOP_INSTR = IF_NOP_INSTR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_valid,
    input  logic [IF_PC_W-1:0]    redirect_pc,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [IF_PC_W-1:0]    iaddr,
    input  logic [IF_INSTR_W-1:0] idata,
    output logic [IF_PC_W-1:0]    id_pc,
    output logic [IF_PC_W-1:0]    id_pc_plus4,
    output logic [IF_INSTR_W-1:0] id_instr,
    output logic                  id_valid,
    output logic                  misalign,
    output logic                  halted,
    output logic [1:0]            dbg_state
);

    logic [IF_PC_W-1:0] pc_q, pc_d;
    logic [1:0]         state_q, state_d;
    logic               misalign_q, misalign_d;

    logic [IF_PC_W-1:0] pc_plus4;
    logic [IF_PC_W-1:0] redirect_aligned;
    logic               ifid_load;
    logic               ifid_bubble;

    // Wraps modulo 2^32 at the top of the address space.
    assign pc_plus4         = pc_q + 32'd4;
    assign redirect_aligned = {redirect_pc[IF_PC_W-1:2], 2'b00};

    always_comb begin
        pc_d        = pc_q;
        state_d     = state_q;
        misalign_d  = 1'b0;
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        case (state_q)
            ST_BOOT: begin
                // First edge out of reset: seed IF/ID with a bubble, ignore inputs.
                ifid_load   = 1'b1;
                ifid_bubble = 1'b1;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_valid) begin
                    // Word at the old pc is wrong-path; it is dropped.
                    pc_d        = redirect_aligned;
                    misalign_d  = |redirect_pc[1:0];
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                    if (halt_req) begin
                        state_d = ST_HALTED;
                    end
                end else if (halt_req) begin
                    // pc holds so the unissued word is fetched again on resume.
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                    state_d     = ST_HALTED;
                end else if (stall) begin
                    ifid_load   = flush;
                    ifid_bubble = 1'b1;
                end else if (flush) begin
                    pc_d        = pc_plus4;
                    ifid_load   = 1'b1;
                    ifid_bubble = 1'b1;
                end else begin
                    pc_d      = pc_plus4;
                    ifid_load = 1'b1;
                end
            end
            ST_HALTED: begin
                ifid_load   = 1'b1;
                ifid_bubble = 1'b1;
                if (redirect_valid) begin
                    // A redirect while halted only retargets; the stage stays halted.
                    pc_d       = redirect_aligned;
                    misalign_d = |redirect_pc[1:0];
                end else if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                ifid_load   = 1'b1;
                ifid_bubble = 1'b1;
                state_d     = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q       <= RESET_PC;
            state_q    <= ST_BOOT;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            state_q    <= state_d;
            misalign_q <= misalign_d;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .load_en     (ifid_load),
        .bubble      (ifid_bubble),
        .pc_in       (pc_q),
        .pc_plus4_in (pc_plus4),
        .instr_in    (idata),
        .id_pc       (id_pc),
        .id_pc_plus4 (id_pc_plus4),
        .id_instr    (id_instr),
        .id_valid    (id_valid)
    );

    assign iaddr     = pc_q;
    assign misalign  = misalign_q;
    assign halted    = (state_q == ST_HALTED);
    assign dbg_state = state_q;

endmodule
